// File: rtl/serial_subtractor.sv
// Bit-serial 5-bit subtractor with borrow-in, LSB first, one bit per cycle.
// Valid/ready on both sides; the result is published all at once on completion.
module serial_subtractor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] p,
    input  logic [4:0] q,
    input  logic       bin,
    output logic [5:0] r,
    output logic       ovf,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state;
    logic [4:0] p_reg;
    logic [4:0] q_reg;
    logic [4:0] diff;
    logic [2:0] cnt;
    logic       borrow;

    logic       a;
    logic       b;
    logic       d;
    logic       nb;
    logic       last;

    assign in_ready = (state == IDLE);

    assign a    = p_reg[cnt];
    assign b    = q_reg[cnt];
    assign d    = a ^ b ^ borrow;
    assign nb   = (~a & b) | (~a & borrow) | (b & borrow);
    assign last = (cnt == 3'd4);

    // Partial difference bits live in diff; r is only written on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            p_reg     <= '0;
            q_reg     <= '0;
            diff      <= '0;
            cnt       <= '0;
            borrow    <= 1'b0;
            r         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        p_reg  <= p;
                        q_reg  <= q;
                        borrow <= bin;
                        cnt    <= '0;
                        diff   <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff[cnt] <= d;
                    borrow    <= nb;
                    cnt       <= cnt + 3'd1;
                    if (last) begin
                        r         <= {nb, d, diff[3:0]};
                        ovf       <= (p_reg[4] != q_reg[4]) & (d != p_reg[4]);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] p;
    logic [4:0] q;
    logic       bin;
    logic [5:0] r;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    serial_subtractor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p        (p),
        .q        (q),
        .bin      (bin),
        .r        (r),
        .ovf      (ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {ovf, r}: r is p - q - bin modulo 64, ovf is signed 5-bit range overflow
    function automatic logic [6:0] ref_sub(input logic [4:0] x,
                                           input logic [4:0] y,
                                           input logic c);
        int u;
        int sx;
        int sy;
        int s;
        logic o;
        u  = int'(x) - int'(y) - int'(c);
        sx = x[4] ? int'(x) - 32 : int'(x);
        sy = y[4] ? int'(y) - 32 : int'(y);
        s  = sx - sy - int'(c);
        o  = (s > 15) || (s < -16);
        return {o, u[5:0]};
    endfunction

    // Model: an operation is "active" from acceptance until released;
    // m_age counts edges since acceptance, result appears 5 edges later.
    bit         m_active;
    int         m_age;
    logic [5:0] m_r;
    logic       m_ovf;
    logic [6:0] m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_r      <= '0;
            m_ovf    <= 1'b0;
            m_exp    <= '0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active <= 1'b1;
                m_age    <= 0;
                m_exp    <= ref_sub(p, q, bin);
            end
        end else if (m_age >= 5) begin
            if (out_ready) m_active <= 1'b0;
        end else begin
            m_age <= m_age + 1;
            if (m_age == 4) begin
                m_r   <= m_exp[5:0];
                m_ovf <= m_exp[6];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_ready", 32'(in_ready), 32'(!m_active));
            check("cmp_out_valid", 32'(out_valid), 32'(m_active && m_age >= 5));
            check("cmp_busy", 32'(busy), 32'(m_active && m_age < 5));
            check("cmp_r", 32'(r), 32'(m_r));
            check("cmp_ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [4:0] pp, input logic [4:0] qq,
                          input logic bb, input logic [5:0] er,
                          input logic eo, input bit release_it);
        int n;
        p        = pp;
        q        = qq;
        bin      = bb;
        in_valid = 1'b1;
        tick();
        n        = 1;
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd6);
        check("lit_out_valid", 32'(out_valid), 32'd1);
        check("lit_r", 32'(r), 32'(er));
        check("lit_ovf", 32'(ovf), 32'(eo));
        if (release_it) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("release_valid", 32'(out_valid), 32'd0);
            check("release_ready", 32'(in_ready), 32'd1);
        end
    endtask

    logic [4:0] bp [4];
    logic [4:0] bq [4];
    logic       bb [4];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        p         = '0;
        q         = '0;
        bin       = 1'b0;
        tick();
        chk_en = 1;
        tick();
        check("rst_r", 32'(r), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(5'd5, 5'd3, 1'b0, 6'b000010, 1'b0, 1);
        run_op(5'd3, 5'd5, 1'b0, 6'b111110, 1'b0, 1);
        run_op(5'd0, 5'd0, 1'b1, 6'b111111, 1'b0, 1);
        run_op(5'b10000, 5'd1, 1'b0, 6'b001111, 1'b1, 1);
        run_op(5'b01111, 5'b10000, 1'b0, 6'b111111, 1'b1, 1);
        run_op(5'd31, 5'd31, 1'b1, 6'b111111, 1'b0, 1);

        // Backpressure with an ignored operand pulse
        run_op(5'd5, 5'd3, 1'b0, 6'b000010, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                p        = 5'd7;
                q        = 5'd1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("bp_r", 32'(r), 32'b000010);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 32'(in_ready), 32'd1);
        tick();
        check("bp_no_queue", 32'(busy), 32'd0);

        // Abort mid-RUN with counter at 2
        p        = 5'd9;
        q        = 5'd4;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_r", 32'(r), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(5'd31, 5'd31, 1'b0, 6'b000000, 1'b0, 1);

        // Back-to-back with in_valid and out_ready held high
        bp[0] = 5'd5;  bq[0] = 5'd3;  bb[0] = 1'b0;
        bp[1] = 5'd3;  bq[1] = 5'd5;  bb[1] = 1'b1;
        bp[2] = 5'd31; bq[2] = 5'd0;  bb[2] = 1'b0;
        bp[3] = 5'd10; bq[3] = 5'd20; bb[3] = 1'b1;
        begin
            int  cyc;
            int  idx;
            int  last_acc;
            bit  acc;
            cyc       = 0;
            idx       = 0;
            last_acc  = 0;
            p         = bp[0];
            q         = bq[0];
            bin       = bb[0];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            while (idx < 4 && cyc < 60) begin
                acc = in_ready;
                tick();
                cyc++;
                if (acc) begin
                    if (idx > 0) check("b2b_gap", 32'(cyc - last_acc), 32'd7);
                    last_acc = cyc;
                    idx++;
                    if (idx < 4) begin
                        p   = bp[idx];
                        q   = bq[idx];
                        bin = bb[idx];
                    end
                end
            end
            in_valid = 1'b0;
            check("b2b_accepts", 32'(idx), 32'd4);
            out_ready = 1'b0;
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            check("b2b_last_valid", 32'(out_valid), 32'd1);
            check("b2b_last_r", 32'(r), 32'b110101);
            check("b2b_last_ovf", 32'(ovf), 32'd1);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            tick();
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
